// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the sequential RV32M/RV64M multiplier.
//   mul_op_e    : request opcode encoding (mul, mulh, mulhsu, mulhu)
//   mul_state_e : control states of mul_unit_seq
//   is_signed_a / is_signed_b / is_legal_op : opcode decode helpers
package mul_pkg;

   typedef enum logic [2:0] {
      MUL_OP_MUL    = 3'b001,
      MUL_OP_MULH   = 3'b010,
      MUL_OP_MULHSU = 3'b011,
      MUL_OP_MULHU  = 3'b100
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } mul_state_e;

   // rs1 is treated as signed for mulh and mulhsu
   function automatic logic is_signed_a(input logic [2:0] op);
      case (op)
         MUL_OP_MULH, MUL_OP_MULHSU: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

   // rs2 is treated as signed for mulh only
   function automatic logic is_signed_b(input logic [2:0] op);
      case (op)
         MUL_OP_MULH: return 1'b1;
         default:     return 1'b0;
      endcase
   endfunction

   function automatic logic is_legal_op(input logic [2:0] op);
      case (op)
         MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: return 1'b1;
         default:                                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mul_step.sv
// mul_step: combinational partial product for one BITS_PER_CYCLE slice of the
// multiplier magnitude, shifted into place and added to the accumulator.
//   acc_i     : running 2*XLEN accumulator
//   a_mag_i   : |rs1|, XLEN+1 bits so the most-negative value is exact
//   b_slice_i : current low slice of the shifted |rs2|
//   iter_i    : slice index (0 = least significant)
//   acc_o     : acc_i + a_mag_i * b_slice_i << (iter_i * BITS_PER_CYCLE)
module mul_step
   import mul_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 4,
   parameter int IW             = 3
) (
   input  logic [2*XLEN-1:0]         acc_i,
   input  logic [XLEN:0]             a_mag_i,
   input  logic [BITS_PER_CYCLE-1:0] b_slice_i,
   input  logic [IW-1:0]             iter_i,
   output logic [2*XLEN-1:0]         acc_o
);

   localparam int AW = 2 * XLEN;
   localparam int SW = $clog2(AW) + 1;

   logic [AW-1:0] pp_s;
   logic [SW-1:0] shamt_s;

   // Partial product and accumulate; the full product never exceeds AW bits
   always_comb begin
      pp_s    = AW'(a_mag_i) * AW'(b_slice_i);
      shamt_s = SW'(iter_i) * SW'(BITS_PER_CYCLE);
      acc_o   = acc_i + (pp_s << shamt_s);
   end

endmodule

// File: rtl/mul_unit_seq.sv
// mul_unit_seq: sequential multiplier for mul/mulh/mulhsu/mulhu.
// Multiplies operand magnitudes BITS_PER_CYCLE bits per clock, applies the
// sign correction, and holds the selected product half until taken.
// Optional feature: define MUL_OPCACHE_EN to keep the last completed product
// so a repeat request on the same operands completes in one cycle.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready/req_op/req_a/req_b : request handshake and operands
//   kill                                   : abort any in-flight operation
//   resp_valid/resp_ready/resp_res/resp_illegal : response handshake
module mul_unit_seq
   import mul_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            kill,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_res,
   output logic            resp_illegal
);

   localparam int AW     = 2 * XLEN;
   localparam int N_ITER = XLEN / BITS_PER_CYCLE;
   localparam int CW     = $clog2(N_ITER + 1);
   localparam int IW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   mul_state_e      state_q, state_d;
   logic [XLEN:0]   a_mag_q, a_mag_d;
   logic [XLEN:0]   b_mag_q, b_mag_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            neg_q, neg_d;
   logic            hi_q, hi_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            ill_q, ill_d;
   logic            ready_q, ready_d;
   logic            valid_q, valid_d;

`ifdef MUL_OPCACHE_EN
   logic            c_vld_q, c_vld_d;
   logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d;
   logic [1:0]      c_cls_q, c_cls_d;
   logic [AW-1:0]   c_prod_q, c_prod_d;
   logic [XLEN-1:0] key_a_q, key_a_d, key_b_q, key_b_d;
   logic [1:0]      key_cls_q, key_cls_d;
`endif

   logic            legal_s, sa_s, sb_s, hit_s;
   logic [XLEN:0]   a_ext_s, b_ext_s;
   logic [XLEN-1:0] hit_res_s;
   logic [AW-1:0]   step_acc_s, fixed_s;
   logic [IW-1:0]   iter_s;

   // Slice index counts up while the iteration counter counts down
   assign iter_s = IW'(CW'(N_ITER) - cnt_q);

   mul_step #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .IW             (IW)
   ) u_step (
      .acc_i     (acc_q),
      .a_mag_i   (a_mag_q),
      .b_slice_i (b_mag_q[BITS_PER_CYCLE-1:0]),
      .iter_i    (iter_s),
      .acc_o     (step_acc_s)
   );

   // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence
   always_comb begin
      state_d = state_q;
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      res_d   = res_q;
      ill_d   = ill_q;
`ifdef MUL_OPCACHE_EN
      c_vld_d   = c_vld_q;
      c_a_d     = c_a_q;
      c_b_d     = c_b_q;
      c_cls_d   = c_cls_q;
      c_prod_d  = c_prod_q;
      key_a_d   = key_a_q;
      key_b_d   = key_b_q;
      key_cls_d = key_cls_q;
`endif

      legal_s = is_legal_op(req_op);
      sa_s    = is_signed_a(req_op);
      sb_s    = is_signed_b(req_op);
      // Sign-extend to XLEN+1 only when the operand is signed for this op
      a_ext_s = {sa_s & req_a[XLEN-1], req_a};
      b_ext_s = {sb_s & req_b[XLEN-1], req_b};
      fixed_s = neg_q ? ({AW{1'b0}} - acc_q) : acc_q;

`ifdef MUL_OPCACHE_EN
      // mul only needs the low half, which is identical for every signedness
      hit_s = c_vld_q && (c_a_q == req_a) && (c_b_q == req_b) &&
              ((req_op == MUL_OP_MUL) || (c_cls_q == {sa_s, sb_s}));
      hit_res_s = (req_op == MUL_OP_MUL) ? c_prod_q[XLEN-1:0] : c_prod_q[AW-1:XLEN];
`else
      hit_s     = 1'b0;
      hit_res_s = {XLEN{1'b0}};
`endif

      if (kill) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && !legal_s) begin
                  res_d   = {XLEN{1'b0}};
                  ill_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (req_valid && hit_s) begin
                  res_d   = hit_res_s;
                  ill_d   = 1'b0;
                  state_d = ST_DONE;
               end else if (req_valid) begin
                  a_mag_d = a_ext_s[XLEN] ? ({(XLEN+1){1'b0}} - a_ext_s) : a_ext_s;
                  b_mag_d = b_ext_s[XLEN] ? ({(XLEN+1){1'b0}} - b_ext_s) : b_ext_s;
                  neg_d   = a_ext_s[XLEN] ^ b_ext_s[XLEN];
                  hi_d    = (req_op != MUL_OP_MUL);
                  acc_d   = {AW{1'b0}};
                  cnt_d   = CW'(N_ITER);
                  state_d = ST_CALC;
`ifdef MUL_OPCACHE_EN
                  key_a_d   = req_a;
                  key_b_d   = req_b;
                  key_cls_d = {sa_s, sb_s};
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CALC: begin
               acc_d   = step_acc_s;
               b_mag_d = b_mag_q >> BITS_PER_CYCLE;
               cnt_d   = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = ST_FIX;
               end else begin
                  state_d = ST_CALC;
               end
            end
            ST_FIX: begin
               acc_d   = fixed_s;
               res_d   = hi_q ? fixed_s[AW-1:XLEN] : fixed_s[XLEN-1:0];
               ill_d   = 1'b0;
               state_d = ST_DONE;
`ifdef MUL_OPCACHE_EN
               c_vld_d  = 1'b1;
               c_a_d    = key_a_q;
               c_b_d    = key_b_q;
               c_cls_d  = key_cls_q;
               c_prod_d = fixed_s;
`endif
            end
            ST_DONE: begin
               if (resp_ready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Handshake outputs are registered from the next state
      valid_d = (state_d == ST_DONE);
      ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_mag_q <= {(XLEN+1){1'b0}};
         b_mag_q <= {(XLEN+1){1'b0}};
         acc_q   <= {AW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         neg_q   <= 1'b0;
         hi_q    <= 1'b0;
         res_q   <= {XLEN{1'b0}};
         ill_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
`ifdef MUL_OPCACHE_EN
         c_vld_q   <= 1'b0;
         c_a_q     <= {XLEN{1'b0}};
         c_b_q     <= {XLEN{1'b0}};
         c_cls_q   <= 2'b00;
         c_prod_q  <= {AW{1'b0}};
         key_a_q   <= {XLEN{1'b0}};
         key_b_q   <= {XLEN{1'b0}};
         key_cls_q <= 2'b00;
`endif
      end else begin
         state_q <= state_d;
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
`ifdef MUL_OPCACHE_EN
         c_vld_q   <= c_vld_d;
         c_a_q     <= c_a_d;
         c_b_q     <= c_b_d;
         c_cls_q   <= c_cls_d;
         c_prod_q  <= c_prod_d;
         key_a_q   <= key_a_d;
         key_b_q   <= key_b_d;
         key_cls_q <= key_cls_d;
`endif
      end
   end

   assign req_ready    = ready_q;
   assign resp_valid   = valid_q;
   assign resp_res     = res_q;
   assign resp_illegal = ill_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// Scoreboard bench for mul_unit_seq (XLEN=32, BITS_PER_CYCLE=4).
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_mul_unit_seq;

   localparam int XLEN = 32;
   localparam int BPC  = 4;
   localparam int NIT  = XLEN / BPC;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready, kill;
   logic [2:0]      req_op;
   logic [XLEN-1:0] req_a, req_b;
   logic            resp_valid, resp_ready, resp_illegal;
   logic [XLEN-1:0] resp_res;

   always #5 clk = ~clk;

   mul_unit_seq #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .kill         (kill),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_res     (resp_res),
      .resp_illegal (resp_illegal)
   );

   typedef struct {
      logic [31:0] res;
      logic        ill;
      int          lat;
      longint      t_acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   hold_cnt = 0;
   bit   rand_bp = 1'b0;

   // reference cache model: last completed full-latency product
   logic        m_vld = 1'b0;
   logic [31:0] m_a, m_b;
   logic [1:0]  m_cls;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, expv, $time);
      end
   endtask

   function automatic logic [1:0] cls_of(input logic [2:0] op);
      return {(op == 3'd2) || (op == 3'd3), (op == 3'd2)};
   endfunction

   // exact 64-bit product from plain signed arithmetic
   function automatic logic [63:0] full_prod(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] ea, eb, p;
      logic [1:0] c;
      c  = cls_of(op);
      ea = c[1] ? {{34{a[31]}}, a} : {34'd0, a};
      eb = c[0] ? {{34{b[31]}}, b} : {34'd0, b};
      p  = ea * eb;
      return p[63:0];
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int kill_at);
      int guard;
      exp_t e;
      logic legal, hit;
      logic [63:0] p;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 64'(req_ready), 64'd1);
         return;
      end
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      e.t_acc = longint'($time);
      #1;
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_a     = 32'($urandom);
      req_b     = 32'($urandom);
      legal = op inside {3'd1, 3'd2, 3'd3, 3'd4};
      p     = full_prod(op, a, b);
      hit   = 1'b0;
`ifdef MUL_OPCACHE_EN
      hit = legal && m_vld && (m_a == a) && (m_b == b) && ((op == 3'd1) || (m_cls == cls_of(op)));
`endif
      if (kill_at > 0 && legal && !hit) begin
         repeat (kill_at - 1) @(posedge clk);
         #1 kill = 1'b1;
         @(posedge clk);
         #1 kill = 1'b0;
         @(negedge clk);
         chk("ready_after_kill", 64'(req_ready), 64'd1);
      end else begin
         e.ill = !legal;
         e.res = !legal ? 32'd0 : ((op == 3'd1) ? p[31:0] : p[63:32]);
         e.lat = (!legal || hit) ? 1 : NIT + 2;
         if (legal && !hit) begin
            m_vld = 1'b1;
            m_a   = a;
            m_b   = b;
            m_cls = cls_of(op);
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || resp_valid) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   // consumer: changes resp_ready just after the active edge
   initial begin
      resp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (hold_cnt > 0) begin
            resp_ready = 1'b0;
            if (resp_valid) hold_cnt--;
         end else if (rand_bp) begin
            resp_ready = ($urandom_range(0, 2) != 0);
         end else begin
            resp_ready = 1'b1;
         end
      end
   end

   // monitor: latency on the valid rise, hold stability, result on handshake
   initial begin
      logic        prev_v;
      logic        prev_ill;
      logic [31:0] prev_res;
      exp_t        e;
      prev_v   = 1'b0;
      prev_ill = 1'b0;
      prev_res = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (resp_valid) chk("req_ready_low_in_done", 64'(req_ready), 64'd0);
            if (resp_valid && !prev_v) begin
               if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
               else chk("latency", 64'((longint'($time) - exp_q[0].t_acc + 5) / 10), 64'(exp_q[0].lat));
            end
            if (resp_valid && prev_v) begin
               chk("hold_res", 64'(resp_res), 64'(prev_res));
               chk("hold_illegal", 64'(resp_illegal), 64'(prev_ill));
            end
            if (resp_valid && resp_ready && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("resp_res", 64'(resp_res), 64'(e.res));
               chk("resp_illegal", 64'(resp_illegal), 64'(e.ill));
            end
            prev_v   = resp_valid;
            prev_res = resp_res;
            prev_ill = resp_illegal;
         end
      end
   end

   initial begin
      logic [31:0] corner [6];
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      int          kat;
      corner[0] = 32'h0000_0000;
      corner[1] = 32'h8000_0000;
      corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h7FFF_FFFF;
      corner[4] = 32'h0000_0001;
      corner[5] = 32'h1234_5678;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 3'd0;
      req_a     = 32'd0;
      req_b     = 32'd0;
      kill      = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_res", 64'(resp_res), 64'd0);
      chk("rst_resp_illegal", 64'(resp_illegal), 64'd0);
      rst = 1'b0;

      issue(3'd1, 32'd7, 32'hFFFF_FFFD, 0);
      issue(3'd2, 32'h8000_0000, 32'h8000_0000, 0);
      issue(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      hold_cnt = 5;
      issue(3'd1, 32'd11, 32'd13, 0);
      issue(3'd2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
      issue(3'd1, 32'd100, 32'd200, 3);
      issue(3'd1, 32'd3, 32'd5, 0);
      issue(3'd7, 32'd9, 32'd9, 0);
      issue(3'd0, 32'd1, 32'd1, 0);
      issue(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      issue(3'd4, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, NIT);
      issue(3'd4, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      wait_drain();

      // reset in the middle of a calculation discards it and clears the cache
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 3'd2;
      req_a     = 32'h1234_5678;
      req_b     = 32'h9ABC_DEF0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_req_ready", 64'(req_ready), 64'd1);
      chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
      chk("midrst_resp_res", 64'(resp_res), 64'd0);
      chk("midrst_resp_illegal", 64'(resp_illegal), 64'd0);
      m_vld = 1'b0;
      rst   = 1'b0;
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0);

      rand_bp = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (i > 0 && $urandom_range(0, 9) < 3) begin
            ra = m_a;
            rb = m_b;
         end else begin
            ra = ($urandom_range(0, 1) != 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            rb = ($urandom_range(0, 1) != 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
         end
         rop = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(1, 4));
         kat = ($urandom_range(0, 7) == 0) ? $urandom_range(1, NIT) : 0;
         issue(rop, ra, rb, kat);
      end
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mul_unit_seq.md
# mul_unit_seq

Parametrised sequential multiplier for the RV32M/RV64M multiply group (mul, mulh, mulhsu, mulhu), sitting in the execute stage beside the ALU. Each request is accepted over a valid/ready handshake. The unit multiplies operand magnitudes at BITS_PER_CYCLE bits per clock, applies the sign correction, and holds the selected half of the 2·XLEN product until the pipeline takes it. It supports abort (kill) of an in-flight operation and optional result reuse for back-to-back high/low pairs.

## Interface
- XLEN, 32, operand/result width; 32 or 64.
- BITS_PER_CYCLE, 4, multiplier bits retired per CALC cycle; power of two, must divide XLEN.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  3  001 mul, 010 mulh, 011 mulhsu, 100 mulhu; all other codes illegal.
- req_a  in  XLEN  rs1 operand.
- req_b  in  XLEN  rs2 operand.
- kill  in  1  abort any in-flight operation (pipeline flush).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_res  out  XLEN  result; low half for mul, high half otherwise.
- resp_illegal  out  1  qualifies resp_valid; request carried an illegal op.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, req_valid=1:
  - Latch |a|, |b| and a product-sign flag. a is signed for mulh and mulhsu; b is signed for mulh only.
  - Latch the high/low select. Clear the 2·XLEN accumulator. Load iteration counter N = XLEN/BITS_PER_CYCLE. Go to CALC.
- IDLE, illegal op: go straight to DONE with resp_res=0 and resp_illegal=1.
- CALC: each cycle, acc += |a| · b_mag[BITS_PER_CYCLE-1:0] << (iteration·BITS_PER_CYCLE); shift b_mag right by BITS_PER_CYCLE; decrement the counter. After N cycles go to FIX.
- FIX: if the sign flag is set, acc = two's-complement of acc, modulo 2^(2·XLEN). Register the selected half into resp_res. Go to DONE.
- DONE: resp_valid=1, outputs held stable. Return to IDLE on resp_ready=1.
- Arithmetic: signed operand magnitudes are XLEN+1 bits wide, so the most-negative value is exact. The full product is exact in 2·XLEN bits for every op.
- kill=1 in any state forces IDLE on the next edge. No response is produced and no result state is updated. kill has priority over req_valid and resp_ready.
- req_op, req_a and req_b are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_res=0, resp_illegal=0; state IDLE, accumulator 0.
- Legal op: accept edge, N CALC cycles, one FIX cycle. resp_valid rises N+2 cycles after the accept edge (XLEN=32, BITS_PER_CYCLE=4: 10 cycles).
- Illegal op: resp_valid rises 1 cycle after the accept edge.
- Throughput: req_ready falls the cycle after accept. It rises the cycle after the DONE handshake, so there is no same-cycle accept during DONE.
- Backpressure: resp_valid, resp_res and resp_illegal hold indefinitely while resp_ready=0.
- rst mid-operation: immediate return to reset values; any partial product is discarded.

## Configuration
- MUL_OPCACHE_EN defined:
  - Store the last completed full product, its a and b, and its signedness class, with a valid bit cleared by rst.
  - A request hits if a and b match and either (a) the op is mul, or (b) the signedness class matches.
  - A hit goes IDLE→DONE, so resp_valid rises 1 cycle after accept. This lets a mulh followed by a mul on the same operands return fast.
  - kill never writes the cache.
- MUL_OPCACHE_EN undefined: no cache storage; every legal op takes N+2 cycles.

## Structure
- Package mul_pkg: the mul_op_e enum (MUL_OP_MUL=3'b001 … MUL_OP_MULHU=3'b100), the mul_state_e enum, and a function is_signed_a/is_signed_b(op).
- Sub-module mul_step: combinational partial-product/accumulate for one BITS_PER_CYCLE slice, parametrised on XLEN and BITS_PER_CYCLE.

## Test plan
- mul, a=7, b=0xFFFFFFFD, XLEN=32, BPC=4 → resp_res=0xFFFFFFEB with resp_valid 10 cycles after accept.
- mulh, a=b=0x80000000 → 0x40000000; mulhu, a=b=0xFFFFFFFF → 0xFFFFFFFE; mulhsu, a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- Hold resp_ready=0 for 5 cycles after resp_valid → outputs stable, req_ready=0; the accept after the handshake succeeds.
- kill on CALC cycle 3 → no resp_valid; req_ready=1 next cycle; the following mul 3×5 returns 15.
- req_op=3'b111 → resp_valid after 1 cycle, resp_res=0, resp_illegal=1.
- MUL_OPCACHE_EN: mulh 0x12345678×0x9ABCDEF0, then mul with the same operands → second result 0x242D2080 after 1 cycle; without the macro, 10 cycles.
